// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default link constants.
package uart_pkg;

    localparam int DEF_CLK_HZ = 100_000_000;
    localparam int DEF_BAUD   = 115_200;
    localparam int DEF_OVS    = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // sclk cycles per oversample tick (truncating division)
    function automatic int baud_div(input int clk_hz, input int baud, input int ovs);
        return clk_hz / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator; one sclk-wide pulse every DIV cycles.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ,
    parameter int BAUD   = DEF_BAUD,
    parameter int OVS    = DEF_OVS
) (
    input  logic sclk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV = baud_div(CLK_HZ, BAUD, OVS);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8 data bits LSB first, optional even parity, one stop bit.
// Output handshake: a byte is transferred on any sclk edge where rx_valid and rx_ready are both high.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = DEF_CLK_HZ,
    parameter int BAUD      = DEF_BAUD,
    parameter int OVS       = DEF_OVS,
    parameter int PARITY_EN = 1
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    localparam int OSW = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [OSW-1:0] OS_MID = OSW'(OVS / 2 - 1);
    localparam logic [OSW-1:0] OS_END = OSW'(OVS - 1);

    logic           sync1, sync2, rxd_q;
    logic           tick;
    uart_state_e    state;
    logic [OSW-1:0] os_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift_reg;
    logic           par_bad;
    logic           fall;
    logic           bit_end;

    uart_baud_tick #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .OVS    (OVS)
    ) u_tick (
        .sclk  (sclk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign fall    = rxd_q & ~sync2;
    assign bit_end = tick && (os_cnt == OS_END);

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            rxd_q      <= 1'b1;
            state      <= ST_IDLE;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bad    <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            rxd_q <= sync2;

            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        state  <= ST_START;
                        os_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (os_cnt == OS_MID) begin
                            // Line back high at mid-start: treat as a glitch
                            if (sync2) begin
                                state <= ST_IDLE;
                            end else begin
                                state   <= ST_DATA;
                                os_cnt  <= '0;
                                bit_cnt <= '0;
                            end
                        end else begin
                            os_cnt <= os_cnt + OSW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        os_cnt    <= '0;
                        shift_reg <= {sync2, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end
                    end else if (tick) begin
                        os_cnt <= os_cnt + OSW'(1);
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        os_cnt  <= '0;
                        par_bad <= (^shift_reg) ^ sync2;
                        state   <= ST_STOP;
                    end else if (tick) begin
                        os_cnt <= os_cnt + OSW'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        os_cnt <= '0;
                        state  <= ST_IDLE;
                        // Load only if the slot is free or being emptied on this edge
                        if (!rx_valid || rx_ready) begin
                            rx_data    <= shift_reg;
                            rx_valid   <= 1'b1;
                            parity_err <= (PARITY_EN != 0) ? par_bad : 1'b0;
                            frame_err  <= ~sync2;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (tick) begin
                        os_cnt <= os_cnt + OSW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven bit by bit, received bytes checked against a queue.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DIV = 54;
    localparam int OVS = 16;
    localparam int BIT = DIV * OVS;

    logic       sclk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    // {parity_err, frame_err, data}
    logic [9:0] exp_q[$];

    uart_rx dut (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        @(negedge sclk);
        rxd = v;
        repeat (BIT - 1) @(negedge sclk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input logic deliver);
        if (deliver) exp_q.push_back({(^d) ^ par, ~stop, d});
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
        bit_time(par);
        bit_time(stop);
        @(negedge sclk);
        rxd = 1'b1;
        repeat (16) @(negedge sclk);
    endtask

    task automatic expect_byte(input string tag);
        int n;
        logic [9:0] e;
        n = 0;
        while (!rx_valid && n < 2 * BIT) begin
            @(negedge sclk);
            n++;
        end
        chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
        chk({tag, "_queue"}, 32'(exp_q.size() != 0), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3ff;
        chk({tag, "_data"}, 32'(rx_data), 32'(e[7:0]));
        chk({tag, "_perr"}, 32'(parity_err), 32'(e[9]));
        chk({tag, "_ferr"}, 32'(frame_err), 32'(e[8]));
    endtask

    task automatic consume(input string tag);
        @(negedge sclk);
        rx_ready = 1'b1;
        @(negedge sclk);
        rx_ready = 1'b0;
        chk({tag, "_cleared"}, 32'(rx_valid), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        repeat (5) @(negedge sclk);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data", 32'(rx_data), 32'h00);
        chk("rst_perr", 32'(parity_err), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
        rst_n = 1'b1;
        repeat (20) @(negedge sclk);

        // Clean frame, correct parity
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        expect_byte("a5");
        consume("a5");

        // Parity bit forced wrong
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        expect_byte("3c");
        consume("3c");

        // Stop bit low, then a good frame
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        expect_byte("55");
        consume("55");
        send_frame(8'h01, 1'b1, 1'b1, 1'b1);
        expect_byte("01");
        consume("01");

        // Short low glitch on idle line
        @(negedge sclk);
        rxd = 1'b0;
        repeat (3 * DIV) @(negedge sclk);
        rxd = 1'b1;
        repeat (2 * BIT) @(negedge sclk);
        chk("glitch_valid", 32'(rx_valid), 32'd0);
        chk("glitch_state", 32'(dut.state), 32'(ST_IDLE));

        // Back-to-back frames with no consumer: second is dropped
        send_frame(8'h11, 1'b0, 1'b1, 1'b1);
        chk("ovr_before", 32'(overrun), 32'd0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        chk("ovr_set", 32'(overrun), 32'd1);
        expect_byte("11");
        consume("11");
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of data bit 4 of 0xF0
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'b0);
        @(negedge sclk);
        rxd = 1'b1;
        repeat (BIT / 2) @(negedge sclk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
        chk("mid_rst_ovr", 32'(overrun), 32'd0);
        chk("mid_rst_valid", 32'(rx_valid), 32'd0);
        chk("mid_rst_data", 32'(rx_data), 32'h00);
        repeat (5) @(negedge sclk);
        rst_n = 1'b1;
        repeat (BIT) @(negedge sclk);
        chk("post_rst_valid", 32'(rx_valid), 32'd0);
        send_frame(8'h0F, 1'b0, 1'b1, 1'b1);
        expect_byte("0f");
        chk("0f_ovr", 32'(overrun), 32'd0);
        consume("0f");

        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate.
REQ-003 SHALL have parameter OVS, default 16, oversampling ticks per bit.
REQ-004 SHALL have parameter PARITY_EN, default 1: 1 means an even-parity bit follows the data; 0 means no parity bit.
REQ-005 SHALL have port sclk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port rxd, input, 1 bit, asynchronous serial line (idle high), LSB-first frames.
REQ-008 SHALL have port rx_data, output, 8 bits, last received data byte.
REQ-009 SHALL have port rx_valid, output, 1 bit, rx_data holds an unconsumed byte.
REQ-010 SHALL have port rx_ready, input, 1 bit, consumer accepts the byte when rx_valid and rx_ready are both high on a sclk edge.
REQ-011 SHALL have port parity_err, output, 1 bit, parity mismatch on the byte in rx_data.
REQ-012 SHALL have port frame_err, output, 1 bit, stop bit sampled low on the byte in rx_data.
REQ-013 SHALL have port overrun, output, 1 bit, sticky; a frame completed while rx_valid was high.

Function
REQ-014 SHALL pass rxd through a two-flop synchronizer (flops reset to 1) before any use.
REQ-015 SHALL generate a one-sclk tick every DIV = CLK_HZ/(BAUD*OVS) sclk cycles (integer division; 54 at the defaults) from a counter running 0..DIV-1.
REQ-016 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-017 In IDLE, a synchronized high-to-low transition SHALL enter START and clear the oversample counter.
REQ-018 In START, the line SHALL be resampled on tick OVS/2-1; if it is high, return to IDLE (false start, no output change); otherwise continue.
REQ-019 After a valid start, each subsequent bit SHALL be sampled every OVS ticks (mid-bit).
REQ-020 In DATA, 8 bits SHALL be sampled LSB first, using a 3-bit bit counter.
REQ-021 PARITY SHALL be skipped when PARITY_EN=0.
REQ-022 In PARITY, error SHALL be flagged if the XOR of the 8 data bits and the parity bit is 1.
REQ-023 On the STOP mid-bit sample, the following SHALL occur on the next sclk: rx_data updates, rx_valid=1, parity_err and frame_err update, and the state returns to IDLE.
REQ-024 A byte with frame_err=1 SHALL still be delivered.
REQ-025 rx_valid SHALL stay high until the handshake and then clear on that edge.
REQ-026 If a frame completes while rx_valid=1 and no handshake occurs on that edge, the new byte SHALL be dropped, rx_data SHALL be held, and overrun SHALL be set.
REQ-027 overrun SHALL clear only on reset.
REQ-028 If a handshake and a frame completion occur on the same edge, the new byte SHALL load, rx_valid SHALL stay 1, and overrun SHALL NOT be set.
REQ-029 After STOP, the next falling edge SHALL be detected without waiting out the rest of the stop bit.

Reset
REQ-030 On rst_n low, these SHALL take effect immediately regardless of sclk: state=IDLE; all counters=0; rx_data=8'h00; rx_valid=0; parity_err=0; frame_err=0; overrun=0; synchronizer flops=1.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; after release, the receiver SHALL wait for a fresh falling edge.

Structure
REQ-032 Package uart_pkg SHALL hold the state enum and the default constants CLK_HZ, BAUD and OVS, shared with the transmit side.
REQ-033 Sub-module uart_baud_tick (parameters CLK_HZ, BAUD, OVS; ports sclk, rst_n, tick) SHALL provide the REQ-015 tick and be reusable by the transmitter.

Verification
REQ-034 The bench SHALL cover: frame 0xA5 with parity 0 and stop 1 at 115200 baud -> rx_data=8'hA5, rx_valid=1, parity_err=0, frame_err=0.
REQ-035 The bench SHALL cover: 0x3C with the parity bit forced to 1 -> rx_data=8'h3C, parity_err=1.
REQ-036 The bench SHALL cover: 0x55 with the stop bit driven 0 -> rx_data=8'h55, frame_err=1, and the next frame 0x01 is received correctly.
REQ-037 The bench SHALL cover: a low glitch of 3 ticks (3*54 sclk) on idle rxd -> no rx_valid, state back to IDLE.
REQ-038 The bench SHALL cover: frames 0x11 then 0x22 with rx_ready=0 -> rx_data=8'h11, overrun=1; raising rx_ready clears rx_valid.
REQ-039 The bench SHALL cover: rst_n pulsed low during data bit 4 of 0xF0, then frame 0x0F -> only 0x0F is delivered, all flags 0.
